// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: register offsets, SoC address window, decode helpers.
package clint_timer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TIME_W = 64;

  // Byte offsets from the CLINT base
  localparam logic [15:0] MSIP        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI    = 16'hBFFC;

  // Window claimed by the CLINT in the SoC decoder
  localparam logic [ADDR_W-1:0] clint_base_addr = 32'h0200_0000;
  localparam logic [ADDR_W-1:0] clint_top_addr  = 32'h0200_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  // Map a base-relative byte address to a register; byte-within-word bits ignored
  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr[31:16] == 16'h0000) begin
      case ({addr[15:2], 2'b00})
        MSIP:        sel = SEL_MSIP;
        MTIMECMP_LO: sel = SEL_CMP_LO;
        MTIMECMP_HI: sel = SEL_CMP_HI;
        MTIME_LO:    sel = SEL_TIME_LO;
        MTIME_HI:    sel = SEL_TIME_HI;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  // Replace the byte lanes selected by strb with the matching bytes of wdata
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_if.sv
// CLINT request/response bus between the interconnect and the timer block.
interface clint_if;
  import clint_timer_pkg::*;

  logic              clint_valid;
  logic              clint_instr;
  logic [ADDR_W-1:0] clint_addr;
  logic [DATA_W-1:0] clint_wdata;
  logic [STRB_W-1:0] clint_wstrb;
  logic [DATA_W-1:0] clint_rdata;
  logic              clint_ready;

  modport master (
    output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    input  clint_rdata, clint_ready
  );

  modport slave (
    input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    output clint_rdata, clint_ready
  );
endinterface

// File: rtl/clint_timer.sv
// RISC-V CLINT: msip, mtimecmp and a prescaled 64-bit mtime with single-cycle bus access.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic              clock,
  input  logic              reset,
  clint_if.slave            bus,
  output logic              clint_msip,
  output logic              clint_mtip,
  output logic [TIME_W-1:0] clint_mtime
);

  localparam int unsigned     PRESC_W    = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(MTIME_DIV - 1);

  logic               msip_q, msip_d;
  logic [TIME_W-1:0]  mtime_q, mtime_d;
  logic [TIME_W-1:0]  mtimecmp_q, mtimecmp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  reg_sel_e sel_c;
  logic     wr_c;
  logic     rd_c;
  logic     tick_c;
  logic     unused_instr;

  assign sel_c        = decode(bus.clint_addr);
  assign wr_c         = bus.clint_valid && (bus.clint_wstrb != '0);
  assign rd_c         = bus.clint_valid && (bus.clint_wstrb == '0);
  assign tick_c       = (presc_q == PRESC_LAST);
  // Fetches are served as plain data accesses
  assign unused_instr = bus.clint_instr;

  // Next-state: prescaler, mtime tick, register writes and read mux
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = tick_c ? '0 : presc_q + PRESC_W'(1);
    mtime_d    = tick_c ? mtime_q + 64'd1 : mtime_q;
    ready_d    = bus.clint_valid;
    rdata_d    = '0;

    // A write to either mtime half replaces the tick for that cycle
    if (wr_c) begin
      case (sel_c)
        SEL_MSIP:    if (bus.clint_wstrb[0]) msip_d = bus.clint_wdata[0];
        SEL_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], bus.clint_wdata, bus.clint_wstrb);
        SEL_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.clint_wdata, bus.clint_wstrb);
        SEL_TIME_LO: mtime_d = {mtime_q[63:32],
                                merge_bytes(mtime_q[31:0], bus.clint_wdata, bus.clint_wstrb)};
        SEL_TIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], bus.clint_wdata, bus.clint_wstrb),
                                mtime_q[31:0]};
        default: ;
      endcase
    end

    if (rd_c) begin
      case (sel_c)
        SEL_MSIP:    rdata_d = DATA_W'(msip_q);
        SEL_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        SEL_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        SEL_TIME_LO: rdata_d = mtime_q[31:0];
        SEL_TIME_HI: rdata_d = mtime_q[63:32];
        default:     rdata_d = '0;
      endcase
    end
  end

  // State and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.clint_ready = ready_q;
  assign bus.clint_rdata = rdata_q;
  assign clint_msip      = msip_q;
  assign clint_mtime     = mtime_q;
  assign clint_mtip      = (mtime_q >= mtimecmp_q);

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed scenarios plus random traffic, two prescaler settings.
module tb_clint_timer;
  import clint_timer_pkg::*;

  logic clock;
  logic reset;

  clint_if bus1();
  clint_if bus3();

  logic        msip1, mtip1, msip3, mtip3;
  logic [63:0] mtime1, mtime3;

  clint_timer #(.MTIME_DIV(1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .clint_msip(msip1), .clint_mtip(mtip1), .clint_mtime(mtime1)
  );

  clint_timer #(.MTIME_DIV(3)) u_dut3 (
    .clock(clock), .reset(reset), .bus(bus3),
    .clint_msip(msip3), .clint_mtip(mtip3), .clint_mtime(mtime3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, index 0 = divide-by-1 device, index 1 = divide-by-3 device
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic        m_msip  [2];
  int unsigned m_cyc   [2];
  int unsigned m_div   [2];
  logic        exp_ready [2];
  logic [31:0] exp_rdata [2];

  logic [15:0] offs [5] = '{MSIP, MTIMECMP_LO, MTIMECMP_HI, MTIME_LO, MTIME_HI};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mtime[k]   = 64'd0;
      m_cmp[k]     = '1;
      m_msip[k]    = 1'b0;
      m_cyc[k]     = 0;
      exp_ready[k] = 1'b0;
      exp_rdata[k] = 32'd0;
    end
    m_div[0] = 1;
    m_div[1] = 3;
  endtask

  function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock edge of the reference: read result, writes, timebase
  task automatic model_edge(input int k, input logic v, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
    logic [15:0] off;
    logic        mapped;
    logic        time_written;
    logic [31:0] rd;
    off          = {a[15:2], 2'b00};
    mapped       = (a[31:16] == 16'h0);
    time_written = 1'b0;
    rd           = 32'd0;
    if (v && st == 4'h0 && mapped) begin
      if (off == MSIP)             rd = {31'd0, m_msip[k]};
      else if (off == MTIMECMP_LO) rd = m_cmp[k][31:0];
      else if (off == MTIMECMP_HI) rd = m_cmp[k][63:32];
      else if (off == MTIME_LO)    rd = m_mtime[k][31:0];
      else if (off == MTIME_HI)    rd = m_mtime[k][63:32];
    end
    exp_ready[k] = v;
    exp_rdata[k] = rd;
    if (v && st != 4'h0 && mapped) begin
      if (off == MSIP && st[0])    m_msip[k] = wd[0];
      else if (off == MTIMECMP_LO) m_cmp[k][31:0]  = put_bytes(m_cmp[k][31:0], wd, st);
      else if (off == MTIMECMP_HI) m_cmp[k][63:32] = put_bytes(m_cmp[k][63:32], wd, st);
      else if (off == MTIME_LO) begin
        m_mtime[k][31:0] = put_bytes(m_mtime[k][31:0], wd, st);
        time_written = 1'b1;
      end else if (off == MTIME_HI) begin
        m_mtime[k][63:32] = put_bytes(m_mtime[k][63:32], wd, st);
        time_written = 1'b1;
      end
    end
    m_cyc[k]++;
    if (!time_written && (m_cyc[k] % m_div[k] == 0)) m_mtime[k] = m_mtime[k] + 64'd1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic ins);
    bus1.clint_valid = v;  bus1.clint_addr = a;  bus1.clint_wdata = wd;
    bus1.clint_wstrb = st; bus1.clint_instr = ins;
    bus3.clint_valid = v;  bus3.clint_addr = a;  bus3.clint_wdata = wd;
    bus3.clint_wstrb = st; bus3.clint_instr = ins;
  endtask

  task automatic compare_all();
    chk("ready_div1", 64'(bus1.clint_ready), 64'(exp_ready[0]));
    chk("rdata_div1", 64'(bus1.clint_rdata), 64'(exp_rdata[0]));
    chk("mtime_div1", mtime1, m_mtime[0]);
    chk("msip_div1",  64'(msip1), 64'(m_msip[0]));
    chk("mtip_div1",  64'(mtip1), 64'(m_mtime[0] >= m_cmp[0]));
    chk("ready_div3", 64'(bus3.clint_ready), 64'(exp_ready[1]));
    chk("rdata_div3", 64'(bus3.clint_rdata), 64'(exp_rdata[1]));
    chk("mtime_div3", mtime3, m_mtime[1]);
    chk("msip_div3",  64'(msip3), 64'(m_msip[1]));
    chk("mtip_div3",  64'(mtip3), 64'(m_mtime[1] >= m_cmp[1]));
  endtask

  // Present a request (or idle), advance one edge, compare everything
  task automatic do_cycle(input logic v, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st);
    drive(v, a, wd, st, 1'($urandom_range(0, 1)));
    model_edge(0, v, a, wd, st);
    model_edge(1, v, a, wd, st);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    logic        seen_rise;
    logic [31:0] ra;
    logic [3:0]  rs;
    int          pick;

    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 64'(bus1.clint_ready), 64'd0);
    chk("rst_rdata", 64'(bus1.clint_rdata), 64'd0);
    chk("rst_mtime", mtime1, 64'd0);
    chk("rst_msip",  64'(msip1), 64'd0);
    chk("rst_mtip",  64'(mtip1), 64'd0);

    reset = 1'b1;
    repeat (10) do_cycle(1'b0, 32'd0, 32'd0, 4'h0);
    chk("idle10_mtime", mtime1, 64'd10);

    // Software interrupt bit
    do_cycle(1'b1, 32'h0000, 32'h1, 4'hF);
    chk("msip_set", 64'(msip1), 64'd1);
    do_cycle(1'b1, 32'h0000, 32'h0, 4'h0);
    chk("msip_read", 64'(bus1.clint_rdata), 64'd1);
    do_cycle(1'b1, 32'h0000, 32'h0, 4'hF);
    chk("msip_clr", 64'(msip1), 64'd0);

    // Timer compare: rise when mtime reaches 20, drop when compare is raised
    do_cycle(1'b1, 32'h4004, 32'd0, 4'hF);
    do_cycle(1'b1, 32'h4000, 32'd20, 4'hF);
    seen_rise = 1'b0;
    for (int i = 0; i < 12; i++) begin
      do_cycle(1'b0, 32'd0, 32'd0, 4'h0);
      if (mtip1 && !seen_rise) begin
        seen_rise = 1'b1;
        chk("mtip_rise_at", mtime1, 64'd20);
      end
    end
    chk("mtip_seen", 64'(seen_rise), 64'd1);
    do_cycle(1'b1, 32'h4000, 32'd100, 4'hF);
    chk("mtip_drop", 64'(mtip1), 64'd0);

    // mtime wrap
    do_cycle(1'b1, 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    do_cycle(1'b1, 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    chk("wrap_load", mtime1, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_mtip", 64'(mtip1), 64'd1);
    do_cycle(1'b0, 32'd0, 32'd0, 4'h0);
    do_cycle(1'b0, 32'd0, 32'd0, 4'h0);
    chk("wrap_zero", mtime1, 64'd0);

    // Byte-lane write and unmapped read
    do_cycle(1'b1, 32'h4000, 32'hFFFF_FFFF, 4'hF);
    do_cycle(1'b1, 32'h4000, 32'h0000_00AB, 4'h1);
    do_cycle(1'b1, 32'h4000, 32'h0, 4'h0);
    chk("lane0_read", 64'(bus1.clint_rdata), 64'hFFFF_FFAB);
    do_cycle(1'b1, 32'h0100, 32'h0, 4'h0);
    chk("unmapped_ready", 64'(bus1.clint_ready), 64'd1);
    chk("unmapped_rdata", 64'(bus1.clint_rdata), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 7));
      if (pick < 5)       ra = {16'h0, offs[pick]};
      else if (pick == 5) ra = {16'h0, 16'($urandom)};
      else if (pick == 6) ra = {16'($urandom_range(1, 16'hFFFF)), offs[$urandom_range(0, 4)]};
      else                ra = {16'h0, offs[$urandom_range(3, 4)]};
      ra[1:0] = 2'($urandom);
      rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      do_cycle(1'($urandom_range(0, 2) != 0), ra, $urandom, rs);
    end

    // Reset asserted while a request is pending
    do_cycle(1'b1, 32'h0000, 32'h1, 4'hF);
    drive(1'b1, 32'h0000, 32'h0, 4'hF, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    chk("midrst_ready", 64'(bus1.clint_ready), 64'd0);
    chk("midrst_rdata", 64'(bus1.clint_rdata), 64'd0);
    chk("midrst_msip",  64'(msip1), 64'd0);
    chk("midrst_mtime", mtime1, 64'd0);
    chk("midrst_mtip",  64'(mtip1), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    do_cycle(1'b0, 32'd0, 32'd0, 4'h0);
    chk("post_rst_ready", 64'(bus1.clint_ready), 64'd0);
    do_cycle(1'b1, 32'h4000, 32'd0, 4'h0);
    do_cycle(1'b1, 32'h4004, 32'd0, 4'h0);
    chk("post_rst_cmp_hi", 64'(bus1.clint_rdata), 64'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 Parameter: MTIME_DIV, default 1, number of clock cycles per mtime increment (legal values 1 and above).
REQ-002 Port: clock, input, 1, single system clock; all state on rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset.
REQ-004 Port: clint_valid, input, 1, request strobe, one cycle per access.
REQ-005 Port: clint_instr, input, 1, fetch flag; ignored, an access is served as a data access.
REQ-006 Port: clint_addr, input, 32, byte offset from the CLINT base (base already subtracted by the interconnect).
REQ-007 Port: clint_wdata, input, 32, write data.
REQ-008 Port: clint_wstrb, input, 4, byte write enables; all zero means read.
REQ-009 Port: clint_rdata, output, 32, read data, valid while clint_ready=1, zero otherwise.
REQ-010 Port: clint_ready, output, 1, one-cycle completion pulse.
REQ-011 Port: clint_msip, output, 1, machine software interrupt pending.
REQ-012 Port: clint_mtip, output, 1, machine timer interrupt pending.
REQ-013 Port: clint_mtime, output, 64, current mtime value.

Function
REQ-014 Register map, word offsets (addr[15:2]; addr[1:0] ignored; addr[31:16] must be 0, else unmapped):
- 0x0000 msip: bit0 R/W, bits 31:1 read 0.
- 0x4000 mtimecmp[31:0].
- 0x4004 mtimecmp[63:32].
- 0xBFF8 mtime[31:0].
- 0xBFFC mtime[63:32].
REQ-015 Every accepted request completes exactly one cycle later: clint_ready=1 for one cycle, clint_rdata registered; no back-pressure; a new request may be issued in the cycle ready is high.
REQ-016 Writes apply per byte lane: lane n written when clint_wstrb[n]=1; update takes effect at the accepting edge.
REQ-017 Reads return the register value as of the accepting edge; a write returns rdata=0.
REQ-018 Unmapped offsets: read 0, writes ignored, ready still asserted.
REQ-019 Timebase: a prescaler counts 0..MTIME_DIV-1; mtime increments by 1 (64-bit, wraps 0xFFFF_FFFF_FFFF_FFFF to 0) on terminal count.
REQ-020 Write to either mtime half in the same cycle as an increment: written bytes take the written value, the increment is dropped that cycle, and unwritten bytes hold.
REQ-021 clint_mtip = (mtime >= mtimecmp), unsigned 64-bit, combinational from registers; it drops as soon as mtimecmp is raised above mtime.
REQ-022 clint_msip = msip bit0 register output.
REQ-023 clint_mtime = mtime register output.

Reset
REQ-024 While reset=0: msip=0, mtime=0, prescaler=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, clint_ready=0, clint_rdata=0; hence clint_mtip=0, clint_msip=0.
REQ-025 A request in flight when reset asserts is discarded; no ready is issued after release.

Structure
REQ-026 Shared package holds the offset constants (MSIP, MTIMECMP_LO/HI, MTIME_LO/HI) and clint_base_addr/clint_top_addr for the SoC decoder.
REQ-027 Single module; no sub-modules.

Verification
REQ-028 Reset release, idle 10 cycles at MTIME_DIV=1 -> clint_mtime=10, mtip=0, msip=0.
REQ-029 Write 0x1 to 0x0000 with wstrb=0xF -> ready next cycle, msip=1; read 0x0000 -> rdata=0x1; write 0 -> msip=0.
REQ-030 Write mtimecmp=20 (0x4004 <- 0, then 0x4000 <- 20) -> mtip rises in the cycle mtime reaches 20; write 0x4000 <- 100 -> mtip falls immediately.
REQ-031 Write 0xBFFC <- 0xFFFFFFFF and 0xBFF8 <- 0xFFFFFFFE -> mtime wraps to 0 two ticks later; mtip asserts while mtime >= mtimecmp.
REQ-032 Write 0xAB to 0x4000 with wstrb=0x1 -> only byte 0 of mtimecmp changes (reads 0xFFFFFFAB); read offset 0x0100 -> rdata=0, ready=1.
REQ-033 Assert reset mid-access -> no ready, all registers at reset values.
